work_byte_assembler: RTL
========================

Name: work_byte_assembler

Overview:
- Receive-side counterpart of the hash-byte transmit path.
- Takes bytes one at a time from the Rx shift register and assembles them into one NUM_BYTES-wide work word (block header) for the scrypt core.
- Presents the completed word with a valid/ack handshake.
- Detects overrun, and optionally inter-byte timeout.

Parameters:
- NUM_BYTES, 80: bytes per work word; must be ≥2.
- TIMEOUT_CYCLES, 100000: idle clocks allowed between bytes of one frame; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe: rx_byte holds a new byte
- rx_byte  in  8  received byte
- abort  in  1  synchronous frame discard
- work_ack  in  1  consumer has taken work_data
- work_data  out  8*NUM_BYTES  assembled word; first byte received lands in [8*NUM_BYTES-1 -: 8]
- work_valid  out  1  work_data complete and stable
- byte_count  out  $clog2(NUM_BYTES+1)  bytes held in the current frame
- overrun_err  out  1  one-cycle pulse: a byte was dropped
- timeout_err  out  1  one-cycle pulse: a frame was abandoned (tied 0 without the optional feature)

Behaviour:
- Reset and clocking:
  - One clock. Asynchronous active-low reset on n_rst.
  - Reset values: all outputs 0; state IDLE.
- States: IDLE, COLLECT, FULL.
- IDLE (byte_count=0):
  - rx_valid → shift byte in, byte_count=1, go to COLLECT.
- COLLECT:
  - Each rx_valid shifts in: work_data <= {work_data[8*NUM_BYTES-9:0], rx_byte}; byte_count+1.
  - On the byte that makes byte_count==NUM_BYTES, go to FULL. work_valid=1 on the next edge, so the word is valid 1 cycle after the last strobe.
- FULL:
  - work_data and work_valid held until work_ack.
  - work_ack → work_valid=0, byte_count=0, go to IDLE.
  - rx_valid without work_ack → byte dropped, overrun_err pulses 1 cycle, stay in FULL.
  - rx_valid and work_ack in the same cycle → word released; the byte becomes byte 1 of a new frame (byte_count=1, go to COLLECT, work_valid=0).
- work_ack outside FULL is ignored.
- work_data is not cleared between frames; contents are meaningful only while work_valid=1.
- abort:
  - Highest priority after reset. Any state → IDLE, byte_count=0, work_valid=0.
  - An rx_valid in the same cycle is discarded with no error pulse.
- byte_count never exceeds NUM_BYTES and never wraps.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: WORK_RX_TIMEOUT_EN.
- Defined:
  - A counter runs in COLLECT, reloads on every accepted byte, and is cleared outside COLLECT.
  - After TIMEOUT_CYCLES clocks with no rx_valid: go to IDLE, byte_count=0, timeout_err pulses 1 cycle.
  - An rx_valid on the expiry cycle wins: the byte is accepted and there is no timeout.
  - IDLE and FULL never time out.
- Undefined:
  - No counter; timeout_err driven constant 0.
  - A partial frame persists until completion or abort.

Decomposition:
- Shared package scrypt_io_pkg:
  - state enum rx_asm_state_t {IDLE, COLLECT, FULL}
  - constant WORK_BYTES=80
  - constant BYTE_W=8
- Natural sub-module: byte_shift_reg. A parameterised NUM_BYTES×8 left-shift register with load-enable, instantiated once.
- FSM, counter and error logic stay in the top module.

Test Plan:
- Reset then stream 0x01..0x50 (80 strobes, 1 per 3 clocks) → work_valid rises 1 cycle after the 80th strobe; work_data[639:632]=0x01, [7:0]=0x50; byte_count=80.
- In FULL, send rx_valid 0xAA with no ack → overrun_err 1-cycle pulse; work_data unchanged; state stays FULL.
- In FULL, rx_valid 0x5C together with work_ack → work_valid=0 next cycle; byte_count=1; work_data[7:0]=0x5C; state COLLECT.
- Send 40 bytes, then abort high 1 cycle with a concurrent rx_valid → byte_count=0; no error pulse. A following full 80-byte frame assembles correctly.
- WORK_RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 5 bytes, then idle 16 clocks → timeout_err pulse, byte_count=0. Repeat with a byte on the 16th clock → no pulse, byte_count=6.
- Assert n_rst low mid-frame (byte_count=30) and in FULL → outputs 0 immediately, asynchronous to clk; state IDLE after release.

Source files
------------

// File: rtl/scrypt_io_pkg.sv
// Shared types and constants for the scrypt work-receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scrypt_io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } rx_asm_state_t;

    localparam int WORK_BYTES = 80;
    localparam int BYTE_W     = 8;

endpackage

// File: rtl/byte_shift_reg.sv
// NUM_BYTES x 8 left-shift register: each load pushes din into the low byte.
// Latency: 1 cycle from load_en to dout.
// Backpressure: none; caller gates load_en.
module byte_shift_reg
    import scrypt_io_pkg::*;
#(
    parameter int NUM_BYTES = WORK_BYTES
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        load_en,
    input  logic [BYTE_W-1:0]           din,
    output logic [BYTE_W*NUM_BYTES-1:0] dout
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dout <= '0;
        end else if (load_en) begin
            dout <= {dout[BYTE_W*NUM_BYTES-BYTE_W-1:0], din};
        end
    end

endmodule

// File: rtl/work_byte_assembler.sv
// Assembles Rx bytes into one NUM_BYTES work word; optional idle timeout via WORK_RX_TIMEOUT_EN.
// Latency: work_valid rises on the edge that captures the last byte of the frame.
// Backpressure: word held until work_ack; bytes arriving while full are dropped with overrun_err.
module work_byte_assembler
    import scrypt_io_pkg::*;
#(
    parameter int NUM_BYTES      = WORK_BYTES,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          rx_valid,
    input  logic [BYTE_W-1:0]             rx_byte,
    input  logic                          abort,
    input  logic                          work_ack,
    output logic [BYTE_W*NUM_BYTES-1:0]   work_data,
    output logic                          work_valid,
    output logic [$clog2(NUM_BYTES+1)-1:0] byte_count,
    output logic                          overrun_err,
    output logic                          timeout_err
);

    localparam int CNT_W = $clog2(NUM_BYTES+1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES-1);

    if (NUM_BYTES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("work_byte_assembler: NUM_BYTES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    rx_asm_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_d;
    logic             shift_en, ovr_d, tmo_d, tmo_fire;

    byte_shift_reg #(.NUM_BYTES(NUM_BYTES)) u_shift (
        .clk     (clk),
        .n_rst   (n_rst),
        .load_en (shift_en),
        .din     (rx_byte),
        .dout    (work_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = byte_count;
        shift_en = 1'b0;
        ovr_d    = 1'b0;
        tmo_d    = 1'b0;
        if (abort) begin
            // a byte arriving alongside abort is silently discarded
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        shift_en = 1'b1;
                        cnt_d    = CNT_W'(1);
                        state_d  = COLLECT;
                    end
                end
                COLLECT: begin
                    if (rx_valid) begin
                        shift_en = 1'b1;
                        cnt_d    = byte_count + CNT_W'(1);
                        if (byte_count == LAST_IDX) state_d = FULL;
                    end else if (tmo_fire) begin
                        tmo_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                FULL: begin
                    if (work_ack) begin
                        // a byte alongside the ack starts the next frame
                        shift_en = rx_valid;
                        cnt_d    = rx_valid ? CNT_W'(1) : '0;
                        state_d  = rx_valid ? COLLECT : IDLE;
                    end else if (rx_valid) begin
                        ovr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            byte_count  <= '0;
            work_valid  <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_count  <= cnt_d;
            work_valid  <= (state_d == FULL);
            overrun_err <= ovr_d;
            timeout_err <= tmo_d;
        end
    end

`ifdef WORK_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES-1);
    logic [TMO_W-1:0] idle_q;

    assign tmo_fire = (idle_q == TMO_LAST);

    // counts idle clocks inside a frame; any accepted byte or state exit restarts it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idle_q <= '0;
        end else if (state_q == COLLECT && state_d == COLLECT && !shift_en) begin
            idle_q <= idle_q + TMO_W'(1);
        end else begin
            idle_q <= '0;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

endmodule
